// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a shared combinational ALU.
// One operation is in flight at a time: accept, execute for one cycle, then hold the result until consumed.
module alu_arbiter #(
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_data1,
  output logic [31:0] alu_data2,
  output logic [1:0]  alu_op,
  input  logic [31:0] alu_d_out,
  input  logic        alu_zero,
  input  logic        alu_ovf,
  output logic        resp_valid,
  output logic        resp_port,
  output logic [31:0] resp_data,
  output logic        resp_zero,
  output logic        resp_ovf,
  input  logic        resp_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic        r_lastServed;
  logic        r_port;
  logic [31:0] r_aluData1;
  logic [31:0] r_aluData2;
  logic [1:0]  r_aluOp;
  logic [31:0] r_respData;
  logic        r_respZero;
  logic        r_respOvf;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;

  // Grants are only offered while idle and never during reset; on contention the port not served last wins.
  always_comb begin
    w_nextState = r_state;
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!rst) begin
          if (req0_valid && (!req1_valid || r_lastServed)) begin
            w_grant0 = 1'b1;
          end else if (req1_valid) begin
            w_grant1 = 1'b1;
          end
        end
        if (w_grant0 || w_grant1) begin
          w_nextState = EXEC;
        end
      end
      EXEC: begin
        w_nextState = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_accept = w_grant0 | w_grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // ALU operands are latched once per acceptance and held; the ALU result is sampled during the single EXEC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lastServed <= ~FIRST_GRANT;
      r_port       <= 1'b0;
      r_aluData1   <= '0;
      r_aluData2   <= '0;
      r_aluOp      <= '0;
      r_respData   <= '0;
      r_respZero   <= 1'b0;
      r_respOvf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_lastServed <= w_grant1;
        r_port       <= w_grant1;
        r_aluData1   <= w_grant1 ? req1_a  : req0_a;
        r_aluData2   <= w_grant1 ? req1_b  : req0_b;
        r_aluOp      <= w_grant1 ? req1_op : req0_op;
      end
      if (r_state == EXEC) begin
        r_respData <= alu_d_out;
        r_respZero <= alu_zero;
        r_respOvf  <= alu_ovf;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign alu_data1  = r_aluData1;
  assign alu_data2  = r_aluData2;
  assign alu_op     = r_aluOp;
  assign resp_valid = (r_state == RESP);
  assign resp_port  = r_port;
  assign resp_data  = r_respData;
  assign resp_zero  = r_respZero;
  assign resp_ovf   = r_respOvf;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: bench-side ALU, transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_data1, alu_data2, alu_d_out;
  logic [1:0]  alu_op;
  logic        alu_zero, alu_ovf;
  logic        resp_valid, resp_port, resp_zero, resp_ovf, resp_ready, busy;
  logic [31:0] resp_data;

  always #5 clk = ~clk;

  alu_arbiter #(.FIRST_GRANT(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
    .alu_d_out(alu_d_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .resp_valid(resp_valid), .resp_port(resp_port), .resp_data(resp_data),
    .resp_zero(resp_zero), .resp_ovf(resp_ovf), .resp_ready(resp_ready), .busy(busy)
  );

  // Shared combinational ALU seen by the arbiter; overflow uses the sign-bit rule.
  always_comb begin
    alu_d_out = '0;
    alu_ovf   = 1'b0;
    alu_zero  = (alu_data1 == alu_data2);
    case (alu_op)
      2'b00: begin
        alu_d_out = alu_data1 + alu_data2;
        alu_ovf   = (alu_data1[31] == alu_data2[31]) && (alu_d_out[31] != alu_data1[31]);
      end
      2'b01: begin
        alu_d_out = alu_data1 - alu_data2;
        alu_ovf   = (alu_data1[31] != alu_data2[31]) && (alu_d_out[31] != alu_data1[31]);
      end
      2'b10: alu_d_out = alu_data1 | alu_data2;
      default: alu_d_out = '0;
    endcase
  end

  localparam longint MAX_S32 = 64'sd2147483647;
  localparam longint MIN_S32 = -MAX_S32 - 1;

  int total = 0;
  int bad   = 0;
  int respCount [2];

  // Reference model state: one pending transaction, its stage (0 executing, 1 responding).
  logic        mPending;
  int          mStage;
  logic        mLast, mPort;
  logic [1:0]  mAluOp;
  logic [31:0] mAluA, mAluB;
  logic [31:0] mResData, mRespData;
  logic        mResZero, mResOvf, mRespZero, mRespOvf;

  logic        snapReady0, snapReady1, snapRespValid, snapPort, snapZero, snapOvf, snapBusy;
  logic [31:0] snapData;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  // Result computed with wide signed arithmetic, range-checked for overflow.
  function automatic void refAlu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] d, output logic z, output logic o);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 0;
    z  = (a == b);
    d  = '0;
    o  = 1'b0;
    case (op)
      2'b00: begin r = sa + sb; d = r[31:0]; o = (r > MAX_S32) || (r < MIN_S32); end
      2'b01: begin r = sa - sb; d = r[31:0]; o = (r > MAX_S32) || (r < MIN_S32); end
      2'b10: d = a | b;
      default: d = '0;
    endcase
  endfunction

  task automatic modelReset();
    mPending  = 1'b0;
    mStage    = 0;
    mLast     = 1'b1;
    mPort     = 1'b0;
    mAluOp    = '0;
    mAluA     = '0;
    mAluB     = '0;
    mRespData = '0;
    mRespZero = 1'b0;
    mRespOvf  = 1'b0;
  endtask

  task automatic applyStimulus(input logic iRst, input logic iV0, input logic iV1,
                               input logic [1:0] iOp0, input logic [31:0] iA0, input logic [31:0] iB0,
                               input logic [1:0] iOp1, input logic [31:0] iA1, input logic [31:0] iB1,
                               input logic iRr);
    logic e0, e1, eResp;
    @(negedge clk);
    rst = iRst;
    req0_valid = iV0; req0_op = iOp0; req0_a = iA0; req0_b = iB0;
    req1_valid = iV1; req1_op = iOp1; req1_a = iA1; req1_b = iB1;
    resp_ready = iRr;
    #1;
    e0 = 1'b0;
    e1 = 1'b0;
    if (!iRst && !mPending) begin
      if (iV0 && iV1) begin
        if (mLast) e0 = 1'b1; else e1 = 1'b1;
      end else if (iV0) begin
        e0 = 1'b1;
      end else if (iV1) begin
        e1 = 1'b1;
      end
    end
    eResp = mPending && (mStage == 1);
    checkOutput("ready0", {31'b0, req0_ready}, {31'b0, e0});
    checkOutput("ready1", {31'b0, req1_ready}, {31'b0, e1});
    checkOutput("busy", {31'b0, busy}, {31'b0, mPending});
    checkOutput("resp_valid", {31'b0, resp_valid}, {31'b0, eResp});
    if (eResp) checkOutput("resp_port", {31'b0, resp_port}, {31'b0, mPort});
    checkOutput("resp_data", resp_data, mRespData);
    checkOutput("resp_zero", {31'b0, resp_zero}, {31'b0, mRespZero});
    checkOutput("resp_ovf", {31'b0, resp_ovf}, {31'b0, mRespOvf});
    checkOutput("alu_op", {30'b0, alu_op}, {30'b0, mAluOp});
    checkOutput("alu_data1", alu_data1, mAluA);
    checkOutput("alu_data2", alu_data2, mAluB);
    snapReady0 = req0_ready; snapReady1 = req1_ready; snapRespValid = resp_valid;
    snapPort = resp_port; snapData = resp_data; snapZero = resp_zero; snapOvf = resp_ovf; snapBusy = busy;
    if (resp_valid === 1'b1 && resp_ready === 1'b1 && resp_port !== 1'bx) respCount[resp_port]++;
    if (iRst) begin
      modelReset();
    end else if (!mPending) begin
      if (e0 || e1) begin
        mPending = 1'b1;
        mStage   = 0;
        mPort    = e1;
        mLast    = e1;
        mAluOp   = e1 ? iOp1 : iOp0;
        mAluA    = e1 ? iA1 : iA0;
        mAluB    = e1 ? iB1 : iB0;
        refAlu(mAluOp, mAluA, mAluB, mResData, mResZero, mResOvf);
      end
    end else if (mStage == 0) begin
      mStage    = 1;
      mRespData = mResData;
      mRespZero = mResZero;
      mRespOvf  = mResOvf;
    end else if (iRr) begin
      mPending = 1'b0;
    end
    @(posedge clk);
  endtask

  task automatic idleCycle(input logic iRr);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, iRr);
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a0, b0, a1, b1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    respCount[0] = 0;
    respCount[1] = 0;
    modelReset();
    repeat (2) @(posedge clk);

    // Reset state, with valid requests that must not be granted while rst is high.
    applyStimulus(1'b1, 1'b1, 1'b1, 2'b00, 32'd1, 32'd2, 2'b00, 32'd3, 32'd4, 1'b1);
    checkOutput("rst_ready0", {31'b0, snapReady0}, 32'd0);

    // Single add from port 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 32'd5, 32'd7, 2'b00, 32'h0, 32'h0, 1'b1);
    checkOutput("add_accept", {31'b0, snapReady0}, 32'd1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("add_valid", {31'b0, snapRespValid}, 32'd1);
    checkOutput("add_data", snapData, 32'd12);
    checkOutput("add_port", {31'b0, snapPort}, 32'd0);

    // Signed overflow from port 1.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'h7FFF_FFFF, 32'd1, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("ovf_data", snapData, 32'h8000_0000);
    checkOutput("ovf_flag", {31'b0, snapOvf}, 32'd1);
    checkOutput("ovf_port", {31'b0, snapPort}, 32'd1);

    // Continuous contention after reset: alternating grants, two responses per port in 12 cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1);
    respCount[0] = 0;
    respCount[1] = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 32'(i), 32'd1, 2'b01, 32'(i), 32'd2, 1'b1);
    end
    checkOutput("rr_count0", 32'(respCount[0]), 32'd2);
    checkOutput("rr_count1", 32'(respCount[1]), 32'd2);

    // Backpressure: sub 3-3 held for 4 cycles while req1 waits.
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b01, 32'd3, 32'd3, 2'b00, 32'd10, 32'd20, 1'b0);
    checkOutput("bp_accept0", {31'b0, snapReady0}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'd10, 32'd20, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'd10, 32'd20, 1'b0);
      checkOutput("bp_data", snapData, 32'd0);
      checkOutput("bp_zero", {31'b0, snapZero}, 32'd1);
      checkOutput("bp_hold1", {31'b0, snapReady1}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'd10, 32'd20, 1'b1);
    checkOutput("bp_hs_ready1", {31'b0, snapReady1}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 32'd10, 32'd20, 1'b1);
    checkOutput("bp_late_ready1", {31'b0, snapReady1}, 32'd1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("bp_req1_data", snapData, 32'd30);

    // Reset while executing: op discarded, next contended grant goes to port 0.
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b10, 32'h3, 32'h4, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00, 32'd9, 32'd9, 2'b00, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00, 32'd1, 32'd1, 2'b00, 32'd2, 32'd2, 1'b1);
    checkOutput("rstx_busy", {31'b0, snapBusy}, 32'd0);
    checkOutput("rstx_valid", {31'b0, snapRespValid}, 32'd0);
    checkOutput("rstx_grant0", {31'b0, snapReady0}, 32'd1);
    idleCycle(1'b1);
    idleCycle(1'b1);

    // OR, then the no-op code.
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b10, 32'hF0, 32'h0F, 2'b00, 32'h0, 32'h0, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("or_data", snapData, 32'hFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0, 2'b11, 32'h5, 32'h9, 1'b1);
    idleCycle(1'b1);
    idleCycle(1'b1);
    checkOutput("none_data", snapData, 32'h0);
    checkOutput("none_ovf", {31'b0, snapOvf}, 32'd0);

    // Randomized traffic with occasional resets and backpressure.
    for (int i = 0; i < 800; i++) begin
      a0 = pickOperand();
      b0 = ($urandom_range(0, 4) == 0) ? a0 : pickOperand();
      a1 = pickOperand();
      b1 = ($urandom_range(0, 4) == 0) ? a1 : pickOperand();
      applyStimulus($urandom_range(0, 39) == 0,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                    2'($urandom_range(0, 3)), a0, b0,
                    2'($urandom_range(0, 3)), a1, b1,
                    $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
